// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared encodings, defaults and update-FSM states for the multi-channel PWM
package pwm_pkg;

  localparam int unsigned DEFAULT_CNT_W = 17;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTRE = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    UPD_IDLE,
    UPD_PENDING
  } upd_state_t;

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: shadow/active duty, compare and registered output
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W,
  parameter logic        INV   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             capture,
  input  logic             commit,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm_out
);

  logic [CNT_W-1:0] duty_sh;
  logic [CNT_W-1:0] duty_act;

  // Shadow duty follows every update strobe; only the last one before a commit matters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_sh <= '0;
    end else if (capture) begin
      duty_sh <= duty;
    end
  end

  // Active duty changes only on commit; an update in the commit cycle bypasses the shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_act <= '0;
    end else if (commit) begin
      duty_act <= capture ? duty : duty_sh;
    end
  end

  // Compare uses the duty in force for the current count, so a commit never clips a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out <= INV;
    end else if (!enable) begin
      pwm_out <= INV;
    end else begin
      pwm_out <= (cnt < duty_act) ^ INV;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - N-channel PWM with shared programmable counter and boundary-synchronous updates
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned        NUM_CH         = 2,
  parameter int unsigned        CNT_W          = DEFAULT_CNT_W,
  parameter int unsigned        DEFAULT_PERIOD = 99999,
  parameter logic [NUM_CH-1:0]  INVERT         = {NUM_CH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [CNT_W-1:0]        period,
  input  logic [NUM_CH*CNT_W-1:0] duty,
  input  logic                    mode,
  input  logic                    update,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_end,
  output logic                    update_ack
);

  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir, dir_nxt;
  logic [CNT_W-1:0] period_act, period_sh;
  logic             mode_act, mode_sh;
  upd_state_t       state, state_nxt;
  logic             pending;
  logic             boundary;
  logic             commit;

  assign pending = (state == UPD_PENDING);
  // While idle there is no period to protect, so a pending update commits straight away.
  assign commit  = (pending || update) && (boundary || !enable);

  // Boundary is the last cycle of a period; P==0 makes every cycle a boundary.
  always_comb begin
    boundary = 1'b0;
    if (period_act == '0) begin
      boundary = 1'b1;
    end else if (mode_act == MODE_EDGE) begin
      boundary = (cnt == period_act);
    end else begin
      // With P==1 the peak and the last down step are the same count value.
      boundary = (cnt == ONE) && ((dir == DIR_DOWN) || (period_act == ONE));
    end
  end

  // Counter walks up (and back down in centre mode); every boundary or idle cycle restarts at 0/up.
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (!enable || boundary) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (dir == DIR_DOWN) begin
      cnt_nxt = cnt - ONE;
    end else if ((mode_act == MODE_CENTRE) && (cnt == period_act)) begin
      cnt_nxt = cnt - ONE;
      dir_nxt = DIR_DOWN;
    end else begin
      cnt_nxt = cnt + ONE;
    end
  end

  // Counter and direction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else begin
      cnt <= cnt_nxt;
      dir <= dir_nxt;
    end
  end

  // Update FSM next state: commit wins over a simultaneous update.
  always_comb begin
    state_nxt = state;
    if (commit) begin
      state_nxt = UPD_IDLE;
    end else if (update) begin
      state_nxt = UPD_PENDING;
    end
  end

  // Update FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= UPD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shadow period/mode capture on every update strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_sh <= '0;
      mode_sh   <= MODE_EDGE;
    end else if (update) begin
      period_sh <= period;
      mode_sh   <= mode;
    end
  end

  // Active period/mode load on commit, direct from the inputs when the update coincides.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_act <= PERIOD_RST;
      mode_act   <= MODE_EDGE;
    end else if (commit) begin
      period_act <= update ? period : period_sh;
      mode_act   <= update ? mode : mode_sh;
    end
  end

  // Status pulses, registered alongside the channel outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_end <= 1'b0;
      update_ack <= 1'b0;
    end else begin
      period_end <= enable && boundary;
      update_ack <= commit;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W (CNT_W),
      .INV   (INVERT[i])
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .capture (update),
      .commit  (commit),
      .cnt     (cnt),
      .duty    (duty[i*CNT_W +: CNT_W]),
      .pwm_out (pwm_out[i])
    );
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- N-channel PWM generator sharing one programmable-period counter. It replaces the fixed 1 kHz, single-channel PWM used for actuator drive.
- Adds runtime period, edge- or centre-aligned counting, per-channel output inversion, and glitch-free double-buffered updates that take effect only at period boundaries.
- Sits between the control logic (duty and period source) and the actuator driver pins.

Parameters:
- NUM_CH, 2, number of PWM channels.
- CNT_W, 17, counter, period and duty width.
- DEFAULT_PERIOD, 99999, active period after reset. Gives a 100000-cycle period, 1 kHz at 100 MHz.
- INVERT, {NUM_CH{1'b0}}, per-channel output polarity mask. Bit=1 inverts that channel.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  run counter; 0 = hold idle.
- period  in  CNT_W  requested terminal count P.
- duty  in  NUM_CH*CNT_W  requested duties; channel i occupies bits [i*CNT_W +: CNT_W].
- mode  in  1  requested mode: 0 = edge-aligned, 1 = centre-aligned.
- update  in  1  single-cycle strobe; captures period, duty and mode into shadow registers.
- pwm_out  out  NUM_CH  registered PWM outputs.
- period_end  out  1  one-cycle pulse marking the boundary.
- update_ack  out  1  one-cycle pulse when shadow values are committed to the active registers.

Behaviour:
- Reset: cnt=0, dir=up, active period=DEFAULT_PERIOD, active duty=0, active mode=0, pending=0, pwm_out=INVERT, period_end=0, update_ack=0.
- Edge mode: cnt runs 0,1,..,P, then wraps to 0. Period is P+1 cycles. Boundary cycle: cnt==P.
- Centre mode: cnt runs 0,1,..,P,P-1,..,1, then 0. Period is 2P cycles. Boundary cycle: dir==down and cnt==1.
- P==0 (either mode): cnt is held at 0 and every cycle is a boundary.
- Compare: raw[i] = (cnt < duty_act[i]), unsigned, full CNT_W.
  - duty 0 gives constant low.
  - duty > cnt maximum gives constant high.
- Registered outputs: pwm_out[i] <= raw[i] ^ INVERT[i]. Latency is 1 cycle from cnt.
- period_end is registered alongside pwm_out and refers to the same cnt value.
- Update handshake:
  - update=1: shadow regs <= inputs and pending <= 1.
  - A repeat update while pending overwrites the shadow regs; only the last one is applied.
- Commit: on a boundary cycle with pending=1 (or update=1 in the same cycle), the active regs load the shadow values.
  - If update and boundary coincide, the active regs load directly from the inputs.
  - pending is cleared, and update_ack pulses on the next cycle.
  - cnt restarts at 0 with dir=up.
- Because the period, mode and duty change only at a boundary, no truncated or runt pulses are produced.
- enable=0:
  - cnt=0 and dir=up.
  - pwm_out=INVERT (idle) and period_end=0.
  - A pending or incoming update commits on the next cycle, with update_ack.
- enable 0->1: counting starts from cnt=0 in the following cycle.
- Async reset mid-period: all state returns to reset values immediately, and shadow contents are discarded.

Decomposition:
- Shared package pwm_pkg holds:
  - mode encoding constants MODE_EDGE=0 and MODE_CENTRE=1;
  - the direction constants;
  - the default CNT_W.
- Sub-module pwm_channel, instantiated NUM_CH times via generate. It contains the shadow duty, active duty, compare and output register.
- It takes cnt, commit, capture, enable and the INVERT bit as inputs.
- The counter/direction logic and the update FSM (IDLE, PENDING) stay in pwm_multi.

Test Plan:
- Use CNT_W=8 and NUM_CH=2 unless stated otherwise.
- 1. Reset, then enable=1. Update with period=9, edge mode, duty={10,3}.
  - Required: update_ack pulses once.
  - ch0 is high exactly 3 of every 10 cycles; ch1 is constantly high.
  - period_end pulses every 10 cycles.
- 2. Edge mode, period=9, duty0=0 and duty1=255.
  - Required: ch0 constantly low, ch1 constantly high.
  - With INVERT=2'b01, ch0 is constantly high instead.
- 3. Edge mode, period=9, duty0=3. Update duty0=7 when cnt=4.
  - Required: the rest of the current period keeps the 3-cycle pulse.
  - update_ack pulses one cycle after the boundary.
  - The next period has a 7-cycle high.
- 4. Centre mode, period=5, duty0=2.
  - Required: period is 10 cycles.
  - High for cnt in {1,0,1} around the valley, i.e. 3 contiguous cycles.
  - period_end pulses once per 10 cycles.
- 5. Two updates (duty0=4, then duty0=6) within one period, the second landing on the boundary cycle.
  - Required: one update_ack, and duty0=6 takes effect in the new period.
- 6. Drop enable at cnt=5, then assert reset mid-period.
  - Required: pwm_out=INVERT the next cycle and period_end stays 0.
  - After reset, the active period is 99999 (CNT_W=17 build).
  - Re-enable restarts cnt from 0.
